// File: rtl/mem_wb_stage.sv
// Memory-access stage: performs loads/stores on an internal multi-cycle RAM and holds the MEM/WB register.
// Latency: non-memory instructions reach wb_* one edge after arrival; memory ops stall LATENCY cycles, result at edge ending cycle LATENCY+1.
// Backpressure: mem_stall freezes upstream stages during an access; inputs must be held stable while it is high.
// Optional feature macro MEM_STORE_POST_EN: posted stores through a one-entry write buffer.
module mem_wb_stage #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mem_m2reg,
    input  logic        mem_wmem,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_rn,
    input  logic [31:0] mem_rb,
    input  logic [31:0] mem_alu_result,
    output logic        mem_stall,
    output logic        wb_m2reg,
    output logic        wb_wreg,
    output logic [4:0]  wb_rn,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_alu_result
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_stall;
    logic                    w_start;
    logic                    w_do_acc;
    logic                    w_acc;
    logic [DEPTH_LOG2-1:0]   w_idx;

    logic [31:0]             r_mem [0:DEPTH-1];
    logic [31:0]             r_rdata;

    logic                    w_we;
    logic [DEPTH_LOG2-1:0]   w_we_idx;
    logic [31:0]             w_we_dat;

    logic                    r_wb_m2reg;
    logic                    r_wb_wreg;
    logic [4:0]              r_wb_rn;
    logic [31:0]             r_wb_mem_data;
    logic [31:0]             r_wb_alu_result;

    // Word address: byte offset and bits above the array size are dropped, so addresses wrap.
    assign w_idx = mem_alu_result[DEPTH_LOG2+1:2];
    assign w_acc = mem_m2reg | mem_wmem;

`ifdef MEM_STORE_POST_EN
    logic                    w_post;
    logic                    w_post_cap;
    logic                    w_drain;
    logic                    r_wbuf_vld;
    logic [CNT_W-1:0]        r_wbuf_cnt;
    logic [DEPTH_LOG2-1:0]   r_wbuf_idx;
    logic [31:0]             r_wbuf_dat;

    // Only a pure store can be posted; load+store keeps the blocking read-before-write path.
    assign w_post     = mem_wmem & ~mem_m2reg;
    assign w_post_cap = (r_state == S_IDLE) & w_acc & w_post & ~r_wbuf_vld;
    assign w_drain    = r_wbuf_vld & (r_wbuf_cnt == CNT_W'(LATENCY - 1));

    // Write buffer: capture a posted store, age it, and release it on the drain edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wbuf_vld <= 1'b0;
            r_wbuf_cnt <= '0;
            r_wbuf_idx <= '0;
            r_wbuf_dat <= '0;
        end else if (w_post_cap) begin
            r_wbuf_vld <= 1'b1;
            r_wbuf_cnt <= '0;
            r_wbuf_idx <= w_idx;
            r_wbuf_dat <= mem_rb;
        end else if (w_drain) begin
            r_wbuf_vld <= 1'b0;
            r_wbuf_cnt <= '0;
        end else if (r_wbuf_vld) begin
            r_wbuf_cnt <= r_wbuf_cnt + CNT_W'(1);
        end
    end

    // RAM write port: a draining buffer never coincides with a blocking access.
    always_comb begin
        w_we     = ~clr & (w_drain | (w_do_acc & mem_wmem));
        w_we_idx = w_drain ? r_wbuf_idx : w_idx;
        w_we_dat = w_drain ? r_wbuf_dat : mem_rb;
    end
`else
    // RAM write port: only the blocking access sequence writes.
    always_comb begin
        w_we     = ~clr & w_do_acc & mem_wmem;
        w_we_idx = w_idx;
        w_we_dat = mem_rb;
    end
`endif

    // Next-state, stall and access-strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_start     = 1'b0;
        w_do_acc    = 1'b0;
        case (r_state)
            S_IDLE: begin
`ifdef MEM_STORE_POST_EN
                if (w_acc && w_post && !r_wbuf_vld) begin
                    w_stall = 1'b0;
                end else if (w_acc && r_wbuf_vld) begin
                    w_stall = 1'b1;
                end else if (w_acc) begin
                    w_start = 1'b1;
                end
`else
                if (w_acc) begin
                    w_start = 1'b1;
                end
`endif
                if (w_start) begin
                    w_stall = 1'b1;
                    if (LATENCY == 1) begin
                        w_do_acc    = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == CNT_W'(LATENCY - 1)) begin
                    w_do_acc    = 1'b1;
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Reset forces the stall low immediately so an aborted access releases upstream at once.
    assign mem_stall = w_stall & ~clr;

    // State and stall-counter register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Data array has no reset so its contents survive clr.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_we_idx] <= w_we_dat;
        end
    end

    // Read-data register: samples the old word on the access edge (read before write).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rdata <= '0;
        end else if (w_do_acc && mem_m2reg) begin
            r_rdata <= r_mem[w_idx];
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the presented instruction.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wb_m2reg      <= 1'b0;
            r_wb_wreg       <= 1'b0;
            r_wb_rn         <= '0;
            r_wb_mem_data   <= '0;
            r_wb_alu_result <= '0;
        end else if (w_stall) begin
            r_wb_m2reg      <= 1'b0;
            r_wb_wreg       <= 1'b0;
            r_wb_rn         <= '0;
            r_wb_mem_data   <= '0;
            r_wb_alu_result <= '0;
        end else begin
            r_wb_m2reg      <= mem_m2reg;
            r_wb_wreg       <= mem_wreg;
            r_wb_rn         <= mem_rn;
            r_wb_mem_data   <= ((r_state == S_DONE) && mem_m2reg) ? r_rdata : 32'h0;
            r_wb_alu_result <= mem_alu_result;
        end
    end

    assign wb_m2reg      = r_wb_m2reg;
    assign wb_wreg       = r_wb_wreg;
    assign wb_rn         = r_wb_rn;
    assign wb_mem_data   = r_wb_mem_data;
    assign wb_alu_result = r_wb_alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (LATENCY=2, DEPTH_LOG2=6).
// Drives inputs 1 time unit after the rising edge, samples at the falling edge or 1 unit after the rising edge.
// Each instruction is held while mem_stall is high; stall cycles are counted with a bounded loop.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        clr;
    logic        mem_m2reg;
    logic        mem_wmem;
    logic        mem_wreg;
    logic [4:0]  mem_rn;
    logic [31:0] mem_rb;
    logic [31:0] mem_alu_result;
    logic        mem_stall;
    logic        wb_m2reg;
    logic        wb_wreg;
    logic [4:0]  wb_rn;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_result;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DEPTH_LOG2(6), .LATENCY(2)) dut (
        .clk            (clk),
        .clr            (clr),
        .mem_m2reg      (mem_m2reg),
        .mem_wmem       (mem_wmem),
        .mem_wreg       (mem_wreg),
        .mem_rn         (mem_rn),
        .mem_rb         (mem_rb),
        .mem_alu_result (mem_alu_result),
        .mem_stall      (mem_stall),
        .wb_m2reg       (wb_m2reg),
        .wb_wreg        (wb_wreg),
        .wb_rn          (wb_rn),
        .wb_mem_data    (wb_mem_data),
        .wb_alu_result  (wb_alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic m2reg, input logic wmem, input logic wreg,
                         input logic [4:0] rn, input logic [31:0] rb, input logic [31:0] alu);
        mem_m2reg      = m2reg;
        mem_wmem       = wmem;
        mem_wreg       = wreg;
        mem_rn         = rn;
        mem_rb         = rb;
        mem_alu_result = alu;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, "_m2reg"}, {31'h0, wb_m2reg}, 32'h0);
        chk({tag, "_wreg"},  {31'h0, wb_wreg},  32'h0);
        chk({tag, "_rn"},    {27'h0, wb_rn},    32'h0);
        chk({tag, "_mdata"}, wb_mem_data,       32'h0);
        chk({tag, "_alu"},   wb_alu_result,     32'h0);
    endtask

    // Present one instruction, hold it through the stall, return 1 unit after the edge that loads wb_*.
    task automatic issue(input string tag, input logic m2reg, input logic wmem, input logic wreg,
                         input logic [4:0] rn, input logic [31:0] rb, input logic [31:0] alu,
                         input int exp_stalls);
        int  stalls;
        bit  done;
        stalls = 0;
        done   = 1'b0;
        drive(m2reg, wmem, wreg, rn, rb, alu);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_stall) begin
                stalls++;
                @(posedge clk);
                #1;
                chk({tag, "_bubble_wreg"}, {31'h0, wb_wreg}, 32'h0);
                chk({tag, "_bubble_alu"}, wb_alu_result, 32'h0);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            chk({tag, "_stall_timeout"}, 32'h0, 32'h1);
        end else begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_stalls"}, stalls, exp_stalls);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic chk_wb(input string tag, input logic m2reg, input logic wreg, input logic [4:0] rn,
                          input logic [31:0] mdata, input logic [31:0] alu);
        chk({tag, "_wb_m2reg"}, {31'h0, wb_m2reg}, {31'h0, m2reg});
        chk({tag, "_wb_wreg"},  {31'h0, wb_wreg},  {31'h0, wreg});
        chk({tag, "_wb_rn"},    {27'h0, wb_rn},    {27'h0, rn});
        chk({tag, "_wb_mdata"}, wb_mem_data,       mdata);
        chk({tag, "_wb_alu"},   wb_alu_result,     alu);
    endtask

    initial begin
        // Reset held with arbitrary inputs: everything must read zero.
        clr = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk_wb_zero("rst");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        clr = 1'b0;
        #1;
        chk("rel_stall", {31'h0, mem_stall}, 32'h0);
        chk_wb_zero("rel");

        // ALU pass-through: no stall, visible one edge later.
        issue("alu", 1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h1234, 0);
        chk_wb("alu", 1'b0, 1'b1, 5'd5, 32'h0, 32'h1234);

`ifdef MEM_STORE_POST_EN
        // First store posts with no stall.
        issue("pst1", 1'b0, 1'b1, 1'b0, 5'd0, 32'h5, 32'h20, 0);
        chk_wb("pst1", 1'b0, 1'b0, 5'd0, 32'h0, 32'h20);
        // Second store waits two cycles for the buffer to drain.
        issue("pst2", 1'b0, 1'b1, 1'b0, 5'd0, 32'h7, 32'h20, 2);
        chk_wb("pst2", 1'b0, 1'b0, 5'd0, 32'h0, 32'h20);
        // Load waits for drain (2) then runs the normal load (2).
        issue("pld", 1'b1, 1'b0, 1'b1, 5'd9, 32'h0, 32'h20, 4);
        chk_wb("pld", 1'b1, 1'b1, 5'd9, 32'h7, 32'h20);
        // A posted store discarded by reset never reaches RAM.
        issue("pst3", 1'b0, 1'b1, 1'b0, 5'd0, 32'h9, 32'h20, 0);
        clr = 1'b1;
        #1;
        chk_wb_zero("pclr");
        @(posedge clk);
        #1;
        clr = 1'b0;
        issue("pld2", 1'b1, 1'b0, 1'b1, 5'd9, 32'h0, 32'h20, 2);
        chk_wb("pld2", 1'b1, 1'b1, 5'd9, 32'h7, 32'h20);
`else
        // Store then load at 0x10.
        issue("st", 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 32'h10, 2);
        chk_wb("st", 1'b0, 1'b0, 5'd0, 32'h0, 32'h10);
        issue("ld", 1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h10, 2);
        chk_wb("ld", 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 32'h10);

        // Preload word 4, then abort a store to it with reset in stall cycle 1.
        issue("pre", 1'b0, 1'b1, 1'b0, 5'd0, 32'h11111111, 32'h10, 2);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h22222222, 32'h10);
        @(negedge clk);
        chk("abort_stall_hi", {31'h0, mem_stall}, 32'h1);
        clr = 1'b1;
        #1;
        chk("abort_stall_lo", {31'h0, mem_stall}, 32'h0);
        chk_wb_zero("abort");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        clr = 1'b0;
        issue("ld_old", 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h10, 2);
        chk_wb("ld_old", 1'b1, 1'b1, 5'd4, 32'h11111111, 32'h10);

        // Address wrap: 0x100 maps onto word 0.
        issue("st0", 1'b0, 1'b1, 1'b0, 5'd0, 32'hA5A50001, 32'h0, 2);
        issue("ldwrap", 1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h100, 2);
        chk_wb("ldwrap", 1'b1, 1'b1, 5'd7, 32'hA5A50001, 32'h100);

        // Load and store together: old word returned, new word written.
        issue("ldst", 1'b1, 1'b1, 1'b1, 5'd8, 32'h33333333, 32'h10, 2);
        chk_wb("ldst", 1'b1, 1'b1, 5'd8, 32'h11111111, 32'h10);
        issue("ld_new", 1'b1, 1'b0, 1'b1, 5'd2, 32'h0, 32'h10, 2);
        chk_wb("ld_new", 1'b1, 1'b1, 5'd2, 32'h33333333, 32'h10);
`endif

        // Trailing non-memory instruction right after an access.
        issue("alu2", 1'b0, 1'b0, 1'b1, 5'd31, 32'h0, 32'hCAFE0003, 0);
        chk_wb("alu2", 1'b0, 1'b1, 5'd31, 32'h0, 32'hCAFE0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
